serial_adder_ctrl: RTL and testbench

- Bit-serial add sequencer built around one full adder (two half adders plus OR for carry).
- Adds two WIDTH-bit operands plus carry-in over WIDTH clock cycles, one bit per cycle, LSB first.
- Carry is held in a flop between cycles. START/BUSY/DONE handshake.
- Used where area matters more than latency; replaces a WIDTH-wide ripple chain of full adders.

---
 rtl/serial_adder_ctrl.sv | 121 ++++++++++++
 tb/tb_serial_adder_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full adder, a carry flop and shift registers, LSB first.
// Optional subtraction enabled by defining SERIAL_SUB_EN.
module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             CIN,
   input  logic             SUB,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] SUM,
   output logic             COUT
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] sha_q;
   logic [WIDTH-1:0] shb_q;
   logic [WIDTH-1:0] shs_q;
   logic [WIDTH-1:0] sum_q;
   logic [CW-1:0]    cnt_q;
   logic             carry_q;
   logic             busy_q;
   logic             done_q;
   logic             cout_q;

   logic             ha0_s, ha0_c, ha1_c, fa_s, fa_c;
   logic [WIDTH-1:0] shs_d;
   logic [WIDTH-1:0] b_load;
   logic             c_load;

   // Full adder built from two half adders plus an OR for the carry.
   always_comb begin
      ha0_s = sha_q[0] ^ shb_q[0];
      ha0_c = sha_q[0] & shb_q[0];
      fa_s  = ha0_s ^ carry_q;
      ha1_c = ha0_s & carry_q;
      fa_c  = ha0_c | ha1_c;
      shs_d = shs_q >> 1;
      shs_d[WIDTH-1] = fa_s;
   end

`ifdef SERIAL_SUB_EN
   // A - B computed as A + ~B + 1; CIN is ignored when subtracting.
   always_comb begin
      b_load = SUB ? ~B : B;
      c_load = SUB ? 1'b1 : CIN;
   end
`else
   logic unused_sub;
   assign unused_sub = SUB;
   always_comb begin
      b_load = B;
      c_load = CIN;
   end
`endif

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= S_IDLE;
         sha_q   <= '0;
         shb_q   <= '0;
         shs_q   <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cout_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               done_q <= 1'b0;
               if (START) begin
                  sha_q   <= A;
                  shb_q   <= b_load;
                  carry_q <= c_load;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= S_RUN;
               end else begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            S_RUN: begin
               sha_q   <= sha_q >> 1;
               shb_q   <= shb_q >> 1;
               shs_q   <= shs_d;
               carry_q <= fa_c;
               cnt_q   <= cnt_q + CW'(1);
               if (cnt_q == CW'(WIDTH - 1)) begin
                  sum_q   <= shs_d;
                  cout_q  <= fa_c;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign BUSY = busy_q;
   assign DONE = done_q;
   assign SUM  = sum_q;
   assign COUT = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: an 8-bit instance and an exhaustively
// checked 3-bit instance sharing one clock and reset.
module tb_serial_adder_ctrl;

   logic       CLK = 1'b0;
   logic       RST;
   logic       start8, cin8, sub8, busy8, done8, cout8;
   logic [7:0] a8, b8, sum8;
   logic       start3, cin3, sub3, busy3, done3, cout3;
   logic [2:0] a3, b3, sum3;

   int total = 0;
   int bad   = 0;

   serial_adder_ctrl #(.WIDTH(8)) dut8 (
      .CLK(CLK), .RST(RST), .START(start8), .A(a8), .B(b8), .CIN(cin8), .SUB(sub8),
      .BUSY(busy8), .DONE(done8), .SUM(sum8), .COUT(cout8));

   serial_adder_ctrl #(.WIDTH(3)) dut3 (
      .CLK(CLK), .RST(RST), .START(start3), .A(a3), .B(b3), .CIN(cin3), .SUB(sub3),
      .BUSY(busy3), .DONE(done3), .SUM(sum3), .COUT(cout3));

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after DONE has dropped.
   task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic cin, input logic sub, input logic [7:0] es, input logic ec);
      int n;
      int bn;
      a8 = a; b8 = b; cin8 = cin; sub8 = sub; start8 = 1'b1;
      @(negedge CLK);
      start8 = 1'b0; a8 = ~a; b8 = ~b; cin8 = ~cin; sub8 = ~sub;
      n  = 1;
      bn = busy8 ? 1 : 0;
      while (!done8 && n < 40) begin
         @(negedge CLK);
         n++;
         if (busy8) bn++;
      end
      $display("txn %s A=%02h B=%02h CIN=%0b SUB=%0b -> SUM=%02h COUT=%0b cycles=%0d",
               tag, a, b, cin, sub, sum8, cout8, n);
      chk({tag, "_latency"}, n, 9);
      chk({tag, "_busy_cycles"}, bn, 8);
      chk({tag, "_sum"}, sum8, es);
      chk({tag, "_cout"}, cout8, ec);
      @(negedge CLK);
      chk({tag, "_done_pulse"}, done8, 1'b0);
   endtask

   task automatic run3(input logic [2:0] a, input logic [2:0] b, input logic cin);
      int n;
      logic [3:0] e;
      e = {1'b0, a} + {1'b0, b} + {3'b000, cin};
      a3 = a; b3 = b; cin3 = cin; start3 = 1'b1;
      @(negedge CLK);
      start3 = 1'b0;
      n = 1;
      while (!done3 && n < 20) begin
         @(negedge CLK);
         n++;
      end
      $display("txn w3 A=%0d B=%0d CIN=%0b -> COUT:SUM=%0d cycles=%0d", a, b, cin, {cout3, sum3}, n);
      chk("w3_latency", n, 4);
      chk("w3_result", {cout3, sum3}, e);
   endtask

   initial begin
      int n;
      int spurious;
      RST = 1'b1;
      start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
      start3 = 1'b0; a3 = '0; b3 = '0; cin3 = 1'b0; sub3 = 1'b0;
      repeat (2) @(negedge CLK);
      chk("rst_busy", busy8, 1'b0);
      chk("rst_done", done8, 1'b0);
      chk("rst_sum", sum8, 8'h00);
      chk("rst_cout", cout8, 1'b0);
      RST = 1'b0;
      @(negedge CLK);

      // Reset pulse while idle.
      #2 RST = 1'b1;
      #1 chk("idle_rst_busy", busy8, 1'b0);
      chk("idle_rst_done", done8, 1'b0);
      @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);

      run8("add_0f_01", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0);
      run8("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
      run8("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1);

      // Back-to-back with START held through DONE, then toggled during RUN.
      a8 = 8'd3; b8 = 8'd4; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
      n = 0;
      do begin
         @(negedge CLK);
         n++;
      end while (!done8 && n < 40);
      $display("txn b2b_1 A=3 B=4 -> SUM=%0d cycles=%0d", sum8, n);
      chk("b2b1_latency", n, 9);
      chk("b2b1_sum", sum8, 8'd7);
      a8 = 8'd10; b8 = 8'd20;
      n = 0;
      do begin
         @(negedge CLK);
         n++;
         if (!done8) begin
            start8 = n[0];
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            cin8 = 1'b1;
         end
      end while (!done8 && n < 40);
      start8 = 1'b0;
      $display("txn b2b_2 A=10 B=20 -> SUM=%0d COUT=%0b spacing=%0d", sum8, cout8, n);
      chk("b2b2_spacing", n, 9);
      chk("b2b2_sum", sum8, 8'd30);
      chk("b2b2_cout", cout8, 1'b0);
      @(negedge CLK);
      chk("b2b_idle_busy", busy8, 1'b0);
      chk("sum_hold", sum8, 8'd30);

      // Reset in the middle of an operation.
      a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0; start8 = 1'b1;
      @(negedge CLK);
      start8 = 1'b0;
      repeat (3) @(negedge CLK);
      chk("midrun_busy", busy8, 1'b1);
      #1 RST = 1'b1;
      #1 chk("midrst_busy", busy8, 1'b0);
      chk("midrst_done", done8, 1'b0);
      chk("midrst_sum", sum8, 8'h00);
      chk("midrst_cout", cout8, 1'b0);
      @(negedge CLK);
      RST = 1'b0;
      spurious = 0;
      repeat (12) begin
         @(negedge CLK);
         if (done8 || busy8) spurious++;
      end
      $display("txn midrst A=AA B=55 aborted");
      chk("midrst_no_done", spurious, 0);
      run8("after_rst", 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0);

`ifdef SERIAL_SUB_EN
      run8("sub_5_7", 8'd5, 8'd7, 1'b0, 1'b1, 8'hFE, 1'b0);
      run8("sub_7_5", 8'd7, 8'd5, 1'b0, 1'b1, 8'h02, 1'b1);
`else
      run8("sub_5_7", 8'd5, 8'd7, 1'b0, 1'b1, 8'h0C, 1'b0);
      run8("sub_7_5", 8'd7, 8'd5, 1'b0, 1'b1, 8'h0C, 1'b0);
`endif

      for (int i = 0; i < 128; i++) begin
         run3(i[2:0], i[5:3], i[6]);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
